// File: rtl/unsaved_nios2_oci_dct_packer.sv
// unsaved_nios2_oci_dct_packer
//
// Packs 2-bit direct-control-transfer (DCT) trace symbols from the Nios II
// OCI trace path into 30-bit frames of up to 15 symbols. The frames feed the
// OCI trace monitor stage. An accumulator collects symbols. A separate output
// register holds the completed frame, so packing can continue while a frame
// waits for the downstream side.
//
// Ports:
//   clk           system clock; all state changes on the rising edge
//   reset_n       asynchronous active-low reset
//   sym_valid     a symbol is offered this cycle
//   sym           DCT symbol
//   sym_ready     symbol accepted when sym_valid && sym_ready
//   flush         single-cycle request to emit a partial frame
//   frame_ready   downstream accepts the presented frame
//   frame_valid   dct_buffer/dct_count hold a frame
//   dct_buffer    packed frame; newest symbol in the low bits
//   dct_count     number of valid symbols in dct_buffer
//   flush_pending flush requested but not yet served
//   dct_drop_cnt  (DCT_PACKER_DROP_EN only) saturating count of dropped symbols
//
// Optional build macro: DCT_PACKER_DROP_EN.
// When it is defined, sym_ready is tied high. A symbol offered while the
// accumulator is full and the output register is busy is discarded and
// counted. When it is not defined, a full accumulator backpressures the
// source instead.

module unsaved_nios2_oci_dct_packer #(
  parameter int SYM_W = 2,
  parameter int DEPTH = 15,
  parameter int CNT_W = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   sym_valid,
  input  logic [SYM_W-1:0]       sym,
  output logic                   sym_ready,
  input  logic                   flush,
  input  logic                   frame_ready,
  output logic                   frame_valid,
  output logic [SYM_W*DEPTH-1:0] dct_buffer,
  output logic [CNT_W-1:0]       dct_count,
`ifdef DCT_PACKER_DROP_EN
  output logic [7:0]             dct_drop_cnt,
`endif
  output logic                   flush_pending
);

  localparam int BUF_W = SYM_W * DEPTH;

  logic [BUF_W-1:0] acc_buf;
  logic [CNT_W-1:0] acc_cnt;

  logic out_free;
  logic fl;
  logic acc_full;
  logic acc_empty;
  logic accept;
  logic xfer;

  // The output register can take a new frame when it is empty, or when its
  // current frame leaves in this same cycle. A full accumulator is always
  // moved out. A partial one is moved out only on a flush request, either
  // live or remembered from an earlier cycle.
  always_comb begin
    out_free  = !frame_valid || frame_ready;
    fl        = flush || flush_pending;
    acc_full  = (acc_cnt == CNT_W'(DEPTH));
    acc_empty = (acc_cnt == '0);
    xfer      = out_free && (acc_full || (fl && !acc_empty));
`ifdef DCT_PACKER_DROP_EN
    sym_ready = 1'b1;
`else
    sym_ready = !acc_full || out_free;
`endif
    // A symbol arriving at a full accumulator is only taken when the
    // accumulator empties in the same cycle. This keeps acc_cnt at or below
    // DEPTH in both builds.
    accept    = sym_valid && (!acc_full || out_free);
  end

  // Accumulator. A transfer empties it. A symbol accepted in the same cycle
  // becomes the first symbol of the next frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_buf <= '0;
      acc_cnt <= '0;
    end else if (xfer) begin
      if (accept) begin
        acc_buf <= {{(BUF_W-SYM_W){1'b0}}, sym};
        acc_cnt <= CNT_W'(1);
      end else begin
        acc_buf <= '0;
        acc_cnt <= '0;
      end
    end else if (accept) begin
      acc_buf <= {acc_buf[BUF_W-SYM_W-1:0], sym};
      acc_cnt <= acc_cnt + CNT_W'(1);
    end
  end

  // Output register. dct_buffer/dct_count keep their last value after the
  // frame is consumed. Only frame_valid drops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dct_buffer  <= '0;
      dct_count   <= '0;
      frame_valid <= 1'b0;
    end else if (xfer) begin
      dct_buffer  <= acc_buf;
      dct_count   <= acc_cnt;
      frame_valid <= 1'b1;
    end else if (frame_valid && frame_ready) begin
      frame_valid <= 1'b0;
    end
  end

  // A flush that cannot be served at once is remembered until the next
  // transfer. A flush that arrives while the accumulator is empty has
  // nothing to emit and is ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flush_pending <= 1'b0;
    end else if (xfer) begin
      flush_pending <= 1'b0;
    end else if (flush && !acc_empty) begin
      flush_pending <= 1'b1;
    end
  end

`ifdef DCT_PACKER_DROP_EN
  // Counts symbols that were discarded because there was nowhere to put
  // them. The count saturates so that a long overflow is not hidden by
  // wrap-around.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dct_drop_cnt <= '0;
    end else if (sym_valid && acc_full && !out_free && (dct_drop_cnt != 8'hFF)) begin
      dct_drop_cnt <= dct_drop_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: doc/unsaved_nios2_oci_dct_packer.md
Name: unsaved_nios2_oci_dct_packer

Overview:
- Upstream feeder of the OCI trace test-bench/monitor stage.
- Packs 2-bit direct-control-transfer (DCT) trace symbols from the Nios II OCI trace path into 30-bit frames of up to 15 symbols.
- Presents each frame as dct_buffer/dct_count with a valid/ready handshake.
- Double-buffered (accumulator plus output register), so packing continues while a frame waits downstream.

Parameters:
- SYM_W, 2, width of one DCT symbol.
- DEPTH, 15, symbols per full frame; buffer width is SYM_W*DEPTH = 30.
- CNT_W, 4, width of the symbol count; must hold DEPTH.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- sym_valid  in  1  symbol offered this cycle.
- sym  in  2  DCT symbol.
- sym_ready  out  1  symbol accepted when sym_valid && sym_ready.
- flush  in  1  single-cycle request to emit a partial frame.
- frame_ready  in  1  downstream accepts frame.
- frame_valid  out  1  dct_buffer/dct_count hold a frame.
- dct_buffer  out  30  packed frame; newest symbol in [1:0].
- dct_count  out  4  number of valid symbols in dct_buffer (1..15).
- flush_pending  out  1  flush requested but not yet served.

Behaviour:
- Reset (async assert, sync release): acc_buf=0, acc_cnt=0, dct_buffer=0, dct_count=0, frame_valid=0, flush_pending=0.
- out_free = !frame_valid || frame_ready.
- fl = flush || flush_pending.
- sym_ready = (acc_cnt != DEPTH) || out_free. Combinational; no dependence on sym_valid.
- A (accept) = sym_valid && sym_ready.
- T (transfer) = out_free && ((acc_cnt == DEPTH) || (fl && acc_cnt != 0)).
- On T:
  - dct_buffer <= acc_buf; dct_count <= acc_cnt; frame_valid <= 1; flush_pending <= 0.
  - If A in the same cycle: acc_buf <= {28'b0, sym}, acc_cnt <= 1. Otherwise acc_buf <= 0, acc_cnt <= 0.
- On A without T: acc_buf <= {acc_buf[27:0], sym}; acc_cnt <= acc_cnt + 1.
  - Never exceeds DEPTH: acceptance at DEPTH implies T.
- Output register with frame_valid && frame_ready and no T: frame_valid <= 0. dct_buffer/dct_count keep their last value.
- flush_pending:
  - Set when flush=1, acc_cnt != 0 and !T.
  - Flush with acc_cnt == 0 is ignored, even if a symbol is accepted that cycle.
  - Repeated flushes while pending merge into one.
- Latency: 15th symbol accepted at edge k; with downstream free, frame_valid=1 and dct_count=15 after edge k+1.
- Flush latency: flush at edge k with acc_cnt=n>0 and out free; frame with dct_count=n after edge k+1.
- Backpressure: frame_valid=1 && !frame_ready && acc_cnt=15 gives sym_ready=0. No symbol is ever lost.
- Stability: while frame_valid && !frame_ready, dct_buffer and dct_count are stable.
- Reset mid-operation: all partial and pending frames are discarded, with no output glitch beyond the async clear.
- Unused upper bits of dct_buffer for partial frames are 0.

Optional Feature:
- Macro: DCT_PACKER_DROP_EN.
- Defined:
  - sym_ready is tied to 1.
  - When acc_cnt == DEPTH and !out_free, the offered symbol is dropped and the accumulator is unchanged.
  - An added output port dct_drop_cnt [7:0] counts drops. It saturates at 255 and clears only on reset.
  - Flush behaviour is unchanged.
- Not defined: backpressure as above. dct_drop_cnt is absent.

Test Plan:
- Full frame: reset, then 15 symbols 2'b01..2'b11 cycling 1,2,3 with frame_ready=1 -> one cycle frame_valid=1, dct_count=15, dct_buffer=30'h1B6DB6DB (sequence 1,2,3 repeated, newest 3 at [1:0]).
- Partial flush: 3 symbols 3,0,2 then flush -> next cycle frame_valid=1, dct_count=3, dct_buffer=30'h00000032.
- Backpressure: frame_ready=0, sym_valid=1 continuously with sym=2'b10:
  - first frame emitted with dct_buffer=30'h2AAAAAAA; accumulator fills to 15, then sym_ready=0;
  - raise frame_ready -> second frame dct_count=15, and the 31st symbol is accepted the same cycle as the transfer (acc_cnt=1).
- Flush while busy: frame held, acc_cnt=4, pulse flush -> flush_pending=1; frame_ready=1 one cycle -> next frame dct_count=4, flush_pending=0.
- Empty flush: flush with acc_cnt=0 -> no frame_valid, flush_pending stays 0.
- Async reset: assert reset_n=0 mid-accumulation (acc_cnt=7, frame_valid=1) -> all outputs 0 immediately; after release, the first frame contains only new symbols.
